encoder_8_to_3_seq: RTL and testbench
=====================================

Name: encoder_8_to_3_seq

Overview:
- Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoders.
- Latches 8 request lines into a pending register and emits one 3-bit index per accepted transfer, highest index first.
- Clears each served bit; serves multi-hot inputs one index at a time over successive cycles.
- Sits between event/request sources and any consumer that needs binary indices.

Parameters:
- None. Width is fixed: 8 request lines, 3-bit index, 4-bit count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- D  input  8  request vector; bit i requests index i
- load  input  1  when high, D is ORed into pending at the next edge
- ready  input  1  consumer accepts Y this cycle when valid is also high
- Y  output  3  encoded index of the selected pending bit
- valid  output  1  high when pending is nonzero
- pending  output  8  current pending register
- count  output  4  number of set bits in pending (0..8)

Behaviour:
- Reset: rst high at a rising edge sets pending=8'h00 and the round-robin pointer (if built) to 3'd0. Outputs then read Y=3'd0, valid=0, count=4'd0.
- rst has priority over load and ready in the same cycle.
- Reset mid-operation drops all pending requests, including the one shown on Y.
- Y, valid and count are combinational decodes of the pending register; there is no extra output register.
- Latency: load with D at edge N gives valid/Y reflecting D from edge N onward (1 cycle from load sampling).
- Selection (default): Y = index of the highest set bit of pending.
- Y=3'd0 whenever pending=0. Y is don't-care for checking when valid=0, but must equal 0.
- Transfer: occurs at an edge where valid=1 and ready=1. The bit at index Y is cleared.
- ready while valid=0 has no effect.
- Next-state rule: pending_next = (pending & ~sel_mask) | (load ? D : 8'h00), where sel_mask is the one-hot of Y on a transfer and 0 otherwise.
- Simultaneous load and transfer: if D re-asserts the bit being served, that bit stays set (new request wins). It is served again later.
- Re-requesting an already pending bit is absorbed: no double-count, no error.
- load with D=8'h00 is a no-op.
- Full state: pending=8'hFF, count=8. Further loads are absorbed. Draining takes exactly 8 transfers with continuous ready.
- Throughput: one index per cycle with ready held high.
- Y must not change while valid=1 and ready=0, unless a load adds a higher-priority bit. Consumers must re-sample Y when ready is asserted.
- count is the population count of pending. Example: pending=8'b1010_0101 gives count=4.

Optional Feature:
- Macro: ENC_ROUND_ROBIN_EN.
- Defined: a 3-bit pointer `last` holds the most recently served index.
  - Reset value of `last` is 0.
  - Selection searches downward starting at (last-1) mod 8, wrapping 0→7, and picks the first set bit.
  - After reset the search starts at 7, so the first selection matches fixed priority.
  - `last` updates to Y on each transfer only.
  - Guarantees no request waits more than 7 transfers.
- Undefined: fixed highest-index priority. No pointer register exists; lower indices can starve under continuous higher-index reloads.

Test Plan:
1. Reset, then load D=8'b0000_1000 → next cycle valid=1, Y=3, count=1. Transfer with ready=1 → pending=0, valid=0, Y=0.
2. Load D=8'hFF, hold ready=1 (default build) → Y sequence 7,6,5,4,3,2,1,0 on consecutive cycles; count 8→0; valid drops after the 8th transfer.
3. pending=8'b0010_0010, ready=0 for 3 cycles → Y held at 5, pending unchanged. Then ready=1 and load D=8'b0010_0000 in the same cycle → bit 5 remains set, Y=5 again next cycle.
4. pending=8'b0100_0001, ready=1, load D=8'b1000_0000 in the same cycle → after the edge pending=8'b1000_0001, Y=7, count=2.
5. Load D=8'b1001_0010, then assert rst together with load D=8'hFF and ready=1 → next cycle pending=0, valid=0, count=0.
6. ENC_ROUND_ROBIN_EN build: load D=8'b1000_0011 and serve 7. Then reload bit 7 every cycle with ready=1 → served sequence 7,1,0,7,7… Bits 1 and 0 are each served before 7 repeats.

Source files
------------

// File: rtl/encoder_8_to_3_seq.sv
// Sequential 8-to-3 encoder: latches requests into a pending register and emits one index per transfer.
// Define ENC_ROUND_ROBIN_EN to replace fixed highest-index priority with a round-robin search.
module encoder_8_to_3_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] D,
    input  logic       load,
    input  logic       ready,
    output logic [2:0] Y,
    output logic       valid,
    output logic [7:0] pending,
    output logic [3:0] count
);

    logic [7:0] pending_q, pending_d;
    logic [2:0] sel;
    logic [7:0] sel_mask;
    logic       xfer;

`ifdef ENC_ROUND_ROBIN_EN
    logic [2:0] last_q, last_d;

    // Search downward from last-1, wrapping 0 -> 7; after reset this starts at 7.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sel   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = last_q - 3'(k);
            if (!found && pending_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (xfer) last_d = sel;
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= 3'd0;
        else     last_q <= last_d;
    end
`else
    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) sel = 3'(i);
        end
    end
`endif

    assign valid = |pending_q;
    assign xfer  = valid & ready;

    always_comb begin
        sel_mask = 8'h00;
        if (xfer) sel_mask[sel] = 1'b1;
        // A re-asserted bit in D is ORed back after the clear, so the new request wins.
        pending_d = (pending_q & ~sel_mask) | (load ? D : 8'h00);
    end

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, pending_q[i]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) pending_q <= 8'h00;
        else     pending_q <= pending_d;
    end

    assign Y       = sel;
    assign pending = pending_q;

endmodule

// File: tb/tb_encoder_8_to_3_seq.sv
// Directed self-checking bench for encoder_8_to_3_seq; expectations are hand-computed constants.
module tb_encoder_8_to_3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] D;
    logic       load;
    logic       ready;
    logic [2:0] Y;
    logic       valid;
    logic [7:0] pending;
    logic [3:0] count;

    int total  = 0;
    int passed = 0;

    encoder_8_to_3_seq dut (
        .clk     (clk),
        .rst     (rst),
        .D       (D),
        .load    (load),
        .ready   (ready),
        .Y       (Y),
        .valid   (valid),
        .pending (pending),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_pend, input logic [3:0] e_cnt,
                             input logic e_valid, input logic [2:0] e_y);
        check({tag, ".pending"}, 32'(pending), 32'(e_pend));
        check({tag, ".count"},   32'(count),   32'(e_cnt));
        check({tag, ".valid"},   32'(valid),   32'(e_valid));
        check({tag, ".Y"},       32'(Y),       32'(e_y));
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; ready = 1'b0; D = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check_all("reset", 8'h00, 4'd0, 1'b0, 3'd0);

        // Single request, then one transfer
        D = 8'b0000_1000; load = 1'b1; tick(); load = 1'b0;
        check_all("t1_load", 8'h08, 4'd1, 1'b1, 3'd3);
        ready = 1'b1; tick(); ready = 1'b0;
        check_all("t1_xfer", 8'h00, 4'd0, 1'b0, 3'd0);

        // Full drain with continuous ready
        D = 8'hFF; load = 1'b1; tick(); load = 1'b0;
        check_all("t2_full", 8'hFF, 4'd8, 1'b1, 3'd7);
        ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            check("t2_y",     32'(Y),     32'(i));
            check("t2_count", 32'(count), 32'(i + 1));
            tick();
        end
        ready = 1'b0;
        check_all("t2_drained", 8'h00, 4'd0, 1'b0, 3'd0);

        // Hold with ready low, then re-request the served bit
        D = 8'b0010_0010; load = 1'b1; tick(); load = 1'b0;
        check_all("t3_load", 8'h22, 4'd2, 1'b1, 3'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("t3_hold", 8'h22, 4'd2, 1'b1, 3'd5);
        end
        ready = 1'b1; load = 1'b1; D = 8'b0010_0000; tick(); load = 1'b0;
        check_all("t3_rereq", 8'h22, 4'd2, 1'b1, 3'd5);
        tick();
        check_all("t3_next", 8'h02, 4'd1, 1'b1, 3'd1);
        tick(); ready = 1'b0;
        check_all("t3_empty", 8'h00, 4'd0, 1'b0, 3'd0);

        // Transfer and higher-priority load in the same cycle
        D = 8'b0100_0001; load = 1'b1; tick(); load = 1'b0;
        check_all("t4_load", 8'h41, 4'd2, 1'b1, 3'd6);
        ready = 1'b1; load = 1'b1; D = 8'b1000_0000; tick(); load = 1'b0; ready = 1'b0;
        check_all("t4_swap", 8'h81, 4'd2, 1'b1, 3'd7);

        // Reset beats load and ready
        D = 8'b1001_0010; load = 1'b1; tick(); load = 1'b0;
        check_all("t5_load", 8'h93, 4'd4, 1'b1, 3'd7);
        rst = 1'b1; load = 1'b1; D = 8'hFF; ready = 1'b1; tick();
        rst = 1'b0; load = 1'b0; ready = 1'b0;
        check_all("t5_rst", 8'h00, 4'd0, 1'b0, 3'd0);

        // Zero load is a no-op; popcount example; saturated loads absorbed
        D = 8'b0000_0101; load = 1'b1; tick();
        check_all("zero_pre", 8'h05, 4'd2, 1'b1, 3'd2);
        D = 8'h00; tick();
        check_all("zero_load", 8'h05, 4'd2, 1'b1, 3'd2);
        D = 8'b1010_0101; tick();
        check_all("popcount", 8'hA5, 4'd4, 1'b1, 3'd7);
        D = 8'hFF; tick();
        check_all("sat1", 8'hFF, 4'd8, 1'b1, 3'd7);
        tick(); load = 1'b0;
        check_all("sat2", 8'hFF, 4'd8, 1'b1, 3'd7);

        // Continuous reload of bit 7: round-robin serves 1 and 0, fixed priority starves them
        do_reset();
        D = 8'b1000_0011; load = 1'b1; tick(); load = 1'b0;
        check_all("t6_load", 8'h83, 4'd3, 1'b1, 3'd7);
        ready = 1'b1; tick();
        check_all("t6_s7", 8'h03, 4'd2, 1'b1, 3'd1);
        D = 8'b1000_0000; load = 1'b1; tick();
`ifdef ENC_ROUND_ROBIN_EN
        check_all("t6_s1", 8'h81, 4'd2, 1'b1, 3'd0);
        tick();
        check_all("t6_s0", 8'h80, 4'd1, 1'b1, 3'd7);
        tick();
        check_all("t6_s7b", 8'h80, 4'd1, 1'b1, 3'd7);
`else
        check_all("t6_s1", 8'h81, 4'd2, 1'b1, 3'd7);
        tick();
        check_all("t6_s7a", 8'h81, 4'd2, 1'b1, 3'd7);
        tick();
        check_all("t6_s7b", 8'h81, 4'd2, 1'b1, 3'd7);
`endif
        load = 1'b0; ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
